// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU control unit.
// Optional feature macro: CPU_INDIRECT_EN (indirect load/store).
package cpu_pkg;

  localparam logic [7:0] START_PC = 8'h80;

  // Opcodes live in IRA[7:4]; C..F decode as NOP.
  typedef enum logic [3:0] {
    OpNop   = 4'h0,
    OpLoad  = 4'h1,
    OpStore = 4'h2,
    OpAdd   = 4'h3,
    OpSub   = 4'h4,
    OpAnd   = 4'h5,
    OpOr    = 4'h6,
    OpHalt  = 4'h7,
    OpSkip  = 4'h8,
    OpJump  = 4'h9,
    OpClear = 4'hA,
    OpNot   = 4'hB
  } opcode_e;

  localparam logic [3:0] AluModeAdd = 4'b0011;
  localparam logic [3:0] AluModeSub = 4'b0100;
  localparam logic [3:0] AluModeAnd = 4'b0101;
  localparam logic [3:0] AluModeOr  = 4'b0110;
  localparam logic [3:0] AluModeNot = 4'b1111;

  // Skip condition codes in IRA[1:0].
  localparam logic [1:0] SkipNeg   = 2'b00;
  localparam logic [1:0] SkipZero  = 2'b01;
  localparam logic [1:0] SkipPos   = 2'b10;
  localparam logic [1:0] SkipNever = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StFaAddr,
    StFaData,
    StFbAddr,
    StFbData,
    StDecode,
    StPtrAddr,
    StPtrData,
    StOpAddr,
    StOpData,
    StExec,
    StStWr,
    StHalt
  } state_e;

  // What follows DECODE for the current instruction.
  typedef enum logic [2:0] {
    PhDone,   // instruction completes in DECODE
    PhNot,    // EXEC without operand read
    PhLoad,
    PhStore,
    PhAlu,    // operand read then EXEC
    PhHalt
  } phase_e;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: phase select, ALU mode and skip evaluation.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ira_i,
  input  logic [7:0] ac_i,
  output logic [2:0] phase_o,
  output logic [3:0] alu_mode_o,
  output logic       skip_taken_o,
  output logic       is_jump_o,
  output logic       is_clear_o
);

  // IRA[3:2] carry no meaning for any opcode.
  logic unused_ira_bits;
  assign unused_ira_bits = ^ira_i[3:2];

  // Decode opcode into the follow-on phase and its side controls.
  always_comb begin
    phase_o      = PhDone;
    alu_mode_o   = 4'b0000;
    skip_taken_o = 1'b0;
    is_jump_o    = 1'b0;
    is_clear_o   = 1'b0;
    case (ira_i[7:4])
      OpLoad:  phase_o = PhLoad;
      OpStore: phase_o = PhStore;
      OpAdd:   begin phase_o = PhAlu; alu_mode_o = AluModeAdd; end
      OpSub:   begin phase_o = PhAlu; alu_mode_o = AluModeSub; end
      OpAnd:   begin phase_o = PhAlu; alu_mode_o = AluModeAnd; end
      OpOr:    begin phase_o = PhAlu; alu_mode_o = AluModeOr;  end
      OpNot:   begin phase_o = PhNot; alu_mode_o = AluModeNot; end
      OpHalt:  phase_o = PhHalt;
      OpSkip: begin
        unique case (ira_i[1:0])
          SkipNeg:   skip_taken_o = ac_i[7];
          SkipZero:  skip_taken_o = (ac_i == 8'h00);
          SkipPos:   skip_taken_o = !ac_i[7] && (ac_i != 8'h00);
          SkipNever: skip_taken_o = 1'b0;
        endcase
      end
      OpJump:  is_jump_o = 1'b1;
      OpClear: is_clear_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional feature macro: CPU_INDIRECT_EN makes load/store indirect through a pointer in mem[IRB].
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       mem_cs,
  output logic       mem_we,
  output logic       mem_oe,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_mode,
  input  logic [7:0] alu_s,
  output logic       halted,
  output logic       instr_done,
  output logic [7:0] pc_o,
  output logic [7:0] ac_o
);

`ifdef CPU_INDIRECT_EN
  localparam bit IndirectEn = 1'b1;
`else
  localparam bit IndirectEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d, ira_q, ira_d, irb_q, irb_d;
  logic [7:0] mbr_q, mbr_d, ac_q, ac_d, ind_q, ind_d;
  logic [7:0] addr_q, addr_d;
  logic       cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic       done;

  logic [2:0] phase;
  logic       skip_taken, is_jump, is_clear;

  cpu_decoder u_decoder (
    .ira_i        (ira_q),
    .ac_i         (ac_q),
    .phase_o      (phase),
    .alu_mode_o   (alu_mode),
    .skip_taken_o (skip_taken),
    .is_jump_o    (is_jump),
    .is_clear_o   (is_clear)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ira_d   = ira_q;
    irb_d   = irb_q;
    mbr_d   = mbr_q;
    ac_d    = ac_q;
    ind_d   = ind_q;
    done    = 1'b0;
    case (state_q)
      StIdle:   if (run) state_d = StFaAddr;
      StFaAddr: state_d = StFaData;
      StFaData: begin
        ira_d   = mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = StFbAddr;
      end
      StFbAddr: state_d = StFbData;
      StFbData: begin
        irb_d   = mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = StDecode;
      end
      StDecode: begin
        case (phase)
          PhLoad:  state_d = IndirectEn ? StPtrAddr : StOpAddr;
          PhStore: state_d = IndirectEn ? StPtrAddr : StStWr;
          PhAlu:   state_d = StOpAddr;
          PhNot:   state_d = StExec;
          PhHalt:  state_d = StHalt;
          default: begin
            done    = 1'b1;
            state_d = StFaAddr;
            // PC already points past the fetched IRB, so skip is a further +2.
            if (is_jump) pc_d = irb_q;
            else if (skip_taken) pc_d = pc_q + 8'd2;
            if (is_clear) ac_d = 8'h00;
          end
        endcase
      end
      StPtrAddr: state_d = StPtrData;
      StPtrData: begin
        ind_d   = mem_rdata;
        state_d = (phase == PhStore) ? StStWr : StOpAddr;
      end
      StOpAddr: state_d = StOpData;
      StOpData: begin
        if (phase == PhLoad) begin
          ac_d    = mem_rdata;
          done    = 1'b1;
          state_d = StFaAddr;
        end else begin
          mbr_d   = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        ac_d    = alu_s;
        done    = 1'b1;
        state_d = StFaAddr;
      end
      StStWr: begin
        done    = 1'b1;
        state_d = StFaAddr;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    // MBR doubles as the write-data register for stores.
    if (state_d == StStWr) mbr_d = ac_q;
  end

  // Memory address and strobes are registered for the state being entered.
  always_comb begin
    case (state_d)
      StFaAddr, StFbAddr: addr_d = pc_d;
      StPtrAddr:          addr_d = irb_d;
      StOpAddr, StStWr:   addr_d = (IndirectEn && phase != PhAlu) ? ind_d : irb_d;
      default:            addr_d = addr_q;
    endcase
    oe_d = (state_d == StFaAddr) || (state_d == StFbAddr) ||
           (state_d == StPtrAddr) || (state_d == StOpAddr);
    we_d = (state_d == StStWr);
    cs_d = oe_d || we_d;
  end

  // State and register file with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= START_PC;
      ira_q   <= 8'h00;
      irb_q   <= 8'h00;
      mbr_q   <= 8'h00;
      ac_q    <= 8'h00;
      ind_q   <= 8'h00;
      addr_q  <= 8'h00;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ira_q   <= ira_d;
      irb_q   <= irb_d;
      mbr_q   <= mbr_d;
      ac_q    <= ac_d;
      ind_q   <= ind_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = mbr_q;
  assign mem_cs     = cs_q;
  assign mem_we     = we_q;
  assign mem_oe     = oe_q;
  assign alu_a      = ac_q;
  assign alu_b      = mbr_q;
  assign halted     = (state_q == StHalt);
  assign instr_done = done;
  assign pc_o       = pc_q;
  assign ac_o       = ac_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Synthesizable control unit for the 8-bit accumulator CPU. Owns PC, IRA, IRB, MBR, AC and the indirect-address register. Sequences fetch/decode/execute against the single-port synchronous 256×8 RAM and the 8-bit `alu`. Sits between the top-level tristate data bus (kept outside this block) and the ALU.

## Interface
- `START_PC`, 8'h80: PC value loaded at reset.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: leaves IDLE when sampled high.
- `mem_addr` output 8: RAM address (MAR), registered.
- `mem_wdata` output 8: write data (MBR).
- `mem_rdata` input 8: RAM read data.
- `mem_cs`, `mem_we`, `mem_oe` outputs 1 each: RAM chip select, write enable, output enable.
- `alu_a`, `alu_b` outputs 8: ALU operands. Driven continuously from AC and MBR.
- `alu_mode` output 4: ALU select.
- `alu_s` input 8: ALU result.
- `halted` output 1: high in HALT.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.
- `pc_o`, `ac_o` outputs 8: debug views of PC and AC.

## Operation
- **States:** IDLE, FA_ADDR, FA_DATA, FB_ADDR, FB_DATA, DECODE, PTR_ADDR, PTR_DATA, OP_ADDR, OP_DATA, EXEC, ST_WR, HALT.
- **Read protocol:** the `*_ADDR` state registers `mem_addr` with `cs=1`, `oe=1`, `we=0`. The following `*_DATA` state captures `mem_rdata`.
- **Write protocol:** ST_WR drives `cs=1`, `we=1`, `oe=0` for exactly one cycle, with `mem_wdata=AC`.
- **Fetch:**
  - IRA ← mem[PC], then PC+1.
  - IRB ← mem[PC], then PC+1.
  - PC wraps from 8'hFF to 8'h00.
- **Decode on IRA[7:4]:**
  - 1 load: AC ← mem[IRB].
  - 2 store: mem[IRB] ← AC.
  - 3 add: MBR ← mem[IRB]; AC ← AC+MBR; `alu_mode` 4'b0011.
  - 4 sub: same operand path; `alu_mode` 4'b0100.
  - 5 and: same operand path; `alu_mode` 4'b0101.
  - 6 or: same operand path; `alu_mode` 4'b0110.
  - B not: AC ← ~AC via `alu_mode` 4'b1111; no operand read.
  - 7 halt: enter HALT.
  - 8 skip: PC ← PC+2 (wrapping) when the condition on IRA[1:0] holds:
    - 00: AC[7]=1 (AC treated as signed, AC<0).
    - 01: AC==0.
    - 10: AC signed >0.
    - 11: never skips.
  - 9 jump: PC ← IRB.
  - A clear: AC ← 0.
  - 0, C–F: NOP.
- **Arithmetic:** 8-bit, carry and overflow discarded. AC is written only from `alu_s`, `mem_rdata` or 0.
- **HALT:** absorbing. Only `rst_n` exits it. `halted`=1 and memory is idle.

## Timing
- **Reset values (asynchronous):**
  - PC=`START_PC`; IRA, IRB, MBR, AC and the indirect-address register = 0.
  - State = IDLE.
  - `mem_cs`/`mem_we`/`mem_oe`=0, `mem_addr`=0, `alu_mode`=0.
  - `halted`=0, `instr_done`=0.
- **IDLE → FA_ADDR:** on the first edge with `run`=1. `run` is ignored afterwards.
- **Cycles per instruction, fetch included (fetch is 4, decode is 1):**
  - skip, jump, clear, NOP: 5.
  - not: 6.
  - store direct: 6; store indirect: 8.
  - load direct: 7; load indirect: 9.
  - add, sub, and, or: 8.
- **`instr_done`:** asserted in the last state of each instruction. Not asserted for halt.
- **Reset mid-write:** `mem_we` drops asynchronously and the write is abandoned.
- **PC update in skip:** uses PC after the fetch increments. Example: skip at 8'h96 moves PC 8'h98 → 8'h9A.

## Configuration
- `CPU_INDIRECT_EN` defined:
  - Load and store are indirect: PTR_ADDR/PTR_DATA read the pointer from mem[IRB] into the indirect-address register, which then addresses the operand.
  - add, sub, and, or stay direct.
- Undefined: load and store are direct, PTR states are unreachable, and the cycle counts are as listed above.

## Structure
- Package `cpu_pkg` holds:
  - opcode enum (4-bit);
  - ALU mode constants (ADD 4'b0011, SUB 4'b0100, AND 4'b0101, OR 4'b0110, NOT 4'b1111);
  - state enum;
  - skip-condition codes.
- Sub-module `cpu_decoder`: combinational. Maps IRA to next-phase selects, `alu_mode` and skip evaluation.
- `cpu_sequencer` itself holds the FSM and all registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-fetch → PC=8'h80, AC=0, all memory strobes 0, `halted`=0. Release with `run`=0 → stays in IDLE with no memory access.
- **Direct load/add:** mem[10]=8'h05, mem[11]=8'hFE; program `load 10`, `add 11` → AC=8'h03 (wrap). `instr_done` pulses at cycles 7 and 15 after `run`.
- **Indirect load (`CPU_INDIRECT_EN`):** mem[40]=8'h50, mem[50]=8'h2A; `load 40` → AC=8'h2A in 9 cycles. Without the macro, the same program gives AC=8'h50 in 7 cycles.
- **Skip conditions:**
  - AC=0, IRA=8'h81 → PC advances by 2.
  - AC=8'h80, IRA=8'h80 → skip.
  - AC=8'h80, IRA=8'h82 → no skip.
  - IRA=8'h83 → never skips.
- **Wrap-around:** instruction at 8'hFE → next fetch from 8'h00. Jump to 8'hFE followed by skip-taken → PC=8'h02.
- **Fibonacci program (indirect):**
  - Setup: t1=1, t2=0, ctr=8'h0A, pos1=1, loop at 8'h80.
  - Expected: halts with mem[sum]=mem[t1]=8'h59, mem[ctr]=0, `halted`=1 and stable for 100 further cycles.
